// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, tag-checks each line coming
// back from prog_mem and hands one instruction per cycle to execute over valid/ready.
module fetch_unit #(
  parameter int PROG_LEN = 7,
  parameter bit WRAP     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  addr,
  input  logic [45:0] line,
  input  logic        redirect_valid,
  input  logic [3:0]  redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_pc,
  output logic [1:0]  out_type,
  output logic [3:0]  out_op,
  output logic [11:0] out_a,
  output logic [11:0] out_b,
  output logic [11:0] out_c,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);
  localparam logic [4:0] LEN_W   = 5'(PROG_LEN);

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic        ov_q, ov_d;
  logic        err_q, err_d;
  logic [3:0]  out_pc_q;
  logic [41:0] fields_q;
  logic        busy_q, done_q;
  logic        load_s, free_s, tag_ok_s, redir_ok_s;

  assign free_s     = !ov_q || out_ready;
  assign tag_ok_s   = (line[45:42] == pc_q);
  assign redir_ok_s = ({1'b0, redirect_addr} < LEN_W);

  // Next-state decisions; redirect outranks both fetch and stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ov_d    = ov_q;
    err_d   = err_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = 4'd0;
          err_d   = 1'b0;
          ov_d    = 1'b0;
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN, DRAIN: begin
        if (redirect_valid) begin
          ov_d = 1'b0;
          if (redir_ok_s) begin
            pc_d    = redirect_addr;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else if (state_q == DRAIN) begin
          if (ov_q && out_ready) begin
            ov_d    = 1'b0;
            state_d = DONE;
          end else begin
            ov_d = ov_q;
          end
        end else if (free_s) begin
          if (!tag_ok_s) begin
            ov_d    = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            load_s = 1'b1;
            ov_d   = 1'b1;
            if (pc_q != LAST_PC) begin
              pc_d = pc_q + 4'd1;
            end else if (WRAP) begin
              pc_d = 4'd0;
            end else begin
              state_d = DRAIN;
            end
          end
        end else begin
          ov_d = ov_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pc, status and instruction output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= 4'd0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
      out_pc_q <= 4'd0;
      fields_q <= 42'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      if (load_s) begin
        out_pc_q <= pc_q;
        fields_q <= line[41:0];
      end
    end
  end

  assign addr      = pc_q;
  assign out_valid = ov_q;
  assign out_pc    = out_pc_q;
  assign out_type  = fields_q[41:40];
  assign out_op    = fields_q[39:36];
  assign out_a     = fields_q[35:24];
  assign out_b     = fields_q[23:12];
  assign out_c     = fields_q[11:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a WRAP=0 and a WRAP=1 instance share one stimulus stream and
// are checked every cycle against a behavioural model, plus directed scenario checks.
module tb_fetch_unit;

  localparam int PL = 7;

  typedef struct {
    logic [1:0] st;   // 0 idle, 1 run, 2 drain, 3 done
    logic [3:0] pc;
    logic       ov;
    logic [3:0] opc;
    logic       has;
    logic       err;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, out_ready, redirect_valid;
  logic [3:0]  redirect_addr;
  logic        cor_en;
  logic [3:0]  cor_at;

  logic [3:0]  addr0, addr1, pc0, pc1, op0, op1;
  logic [45:0] line0, line1;
  logic        ov0, ov1, busy0, busy1, done0, done1, err0, err1;
  logic [1:0]  ty0, ty1;
  logic [11:0] a0, a1, b0, b1, c0, c1;

  int   n_chk = 0;
  int   n_fail = 0;
  mdl_t m0, m1;

  always #5 clk = ~clk;

  function automatic logic [45:0] mem_line(input logic [3:0] a, input logic bad);
    logic [3:0] tag;
    tag = bad ? ~a : a;
    return {tag, a[1:0], 4'd5, {8'd0, a} + 12'd1, 12'h100 | {8'd0, a}, 12'hA50 ^ {8'd0, a}};
  endfunction

  assign line0 = mem_line(addr0, cor_en && (addr0 == cor_at));
  assign line1 = mem_line(addr1, cor_en && (addr1 == cor_at));

  fetch_unit #(.PROG_LEN(PL), .WRAP(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .addr(addr0), .line(line0),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(ov0), .out_ready(out_ready), .out_pc(pc0), .out_type(ty0),
    .out_op(op0), .out_a(a0), .out_b(b0), .out_c(c0),
    .busy(busy0), .done(done0), .err(err0)
  );

  fetch_unit #(.PROG_LEN(PL), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .addr(addr1), .line(line1),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(ov1), .out_ready(out_ready), .out_pc(pc1), .out_type(ty1),
    .out_op(op1), .out_a(a1), .out_b(b1), .out_c(c1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.st = 2'd0; m.pc = 4'd0; m.ov = 1'b0; m.opc = 4'd0; m.has = 1'b0; m.err = 1'b0;
    return m;
  endfunction

  // One clock of the fetch rules, applied to the inputs currently driven.
  function automatic mdl_t step(input mdl_t m, input bit wrap);
    bit running;
    running = (m.st == 2'd1) || (m.st == 2'd2);
    if (!running) begin
      if (start) begin
        m.st = 2'd1; m.pc = 4'd0; m.err = 1'b0; m.ov = 1'b0;
      end
    end else if (redirect_valid) begin
      m.ov = 1'b0;
      if (int'(redirect_addr) < PL) begin
        m.pc = redirect_addr; m.st = 2'd1;
      end else begin
        m.err = 1'b1; m.st = 2'd3;
      end
    end else if (m.st == 2'd2) begin
      if (m.ov && out_ready) begin
        m.ov = 1'b0; m.st = 2'd3;
      end
    end else if (!m.ov || out_ready) begin
      if (cor_en && m.pc == cor_at) begin
        m.ov = 1'b0; m.err = 1'b1; m.st = 2'd3;
      end else begin
        m.opc = m.pc; m.has = 1'b1; m.ov = 1'b1;
        if (int'(m.pc) != PL - 1) m.pc = m.pc + 4'd1;
        else if (wrap) m.pc = 4'd0;
        else m.st = 2'd2;
      end
    end
    return m;
  endfunction

  task automatic cmp_inst(input string nm, input mdl_t m, input logic [53:0] obs);
    logic [45:0] ln;
    logic [53:0] exp;
    ln  = m.has ? mem_line(m.opc, 1'b0) : 46'd0;
    exp = {m.pc, m.ov, m.opc, ln[41:0], (m.st == 2'd1) || (m.st == 2'd2), m.st == 2'd3, m.err};
    check_eq({nm, "_addr"},   64'(obs[53:50]), 64'(exp[53:50]));
    check_eq({nm, "_valid"},  64'(obs[49]),    64'(exp[49]));
    check_eq({nm, "_outpc"},  64'(obs[48:45]), 64'(exp[48:45]));
    check_eq({nm, "_fields"}, 64'(obs[44:3]),  64'(exp[44:3]));
    check_eq({nm, "_status"}, 64'(obs[2:0]),   64'(exp[2:0]));
  endtask

  task automatic compare_both();
    cmp_inst("u0", m0, {addr0, ov0, pc0, ty0, op0, a0, b0, c0, busy0, done0, err0});
    cmp_inst("u1", m1, {addr1, ov1, pc1, ty1, op1, a1, b1, c1, busy1, done1, err1});
  endtask

  task automatic cycle();
    m0 = step(m0, 1'b0);
    m1 = step(m1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    compare_both();
  endtask

  task automatic wait_pc0(input logic [3:0] p, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ov0 && pc0 == p) found = 1'b1;
      else cycle();
    end
    check_eq(tag, 64'(found), 64'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_addr = 4'd0; cor_en = 1'b0; cor_at = 4'd0;
    m0 = mdl_rst(); m1 = mdl_rst();
    repeat (2) @(negedge clk);
    compare_both();
    rst = 1'b1;

    // Full program, then WRAP instance keeps streaming; start mid-run is ignored by u1.
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      start = (i == 10);
      cycle();
      if (i < PL) begin
        check_eq("run_pc", 64'(pc0), 64'(i));
        check_eq("run_op", 64'(op0), 64'd5);
        check_eq("run_a",  64'(a0),  64'(i + 1));
      end
      if (i == PL) begin
        check_eq("run_done", 64'(done0), 64'd1);
        check_eq("run_err",  64'(err0),  64'd0);
      end
      check_eq("wrap_pc",    64'(pc1),   64'(i % PL));
      check_eq("wrap_valid", 64'(ov1),   64'd1);
      check_eq("wrap_busy",  64'(busy1), 64'd1);
    end
    start = 1'b0;

    // Back-pressure while entry 2 is presented.
    wait_pc0(4'd2, "wait_pc2");
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      check_eq("stall_addr", 64'(addr0), 64'd3);
      check_eq("stall_a",    64'(a0),    64'd3);
      check_eq("stall_pc",   64'(pc0),   64'd2);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("resume_pc", 64'(pc0), 64'd3);

    // Redirect to 1 while entry 4 is presented: one bubble.
    wait_pc0(4'd4, "wait_pc4");
    redirect_valid = 1'b1; redirect_addr = 4'd1;
    cycle();
    redirect_valid = 1'b0;
    check_eq("redir_bubble", 64'(ov0), 64'd0);
    cycle();
    check_eq("redir_pc", 64'(pc0), 64'd1);
    check_eq("redir_a",  64'(a0),  64'd2);
    cycle();
    check_eq("redir_next", 64'(pc0), 64'd2);

    // Out-of-range redirect, then restart clears err.
    redirect_valid = 1'b1; redirect_addr = 4'd9;
    cycle();
    redirect_valid = 1'b0;
    check_eq("bad_err",   64'(err0),  64'd1);
    check_eq("bad_done",  64'(done0), 64'd1);
    check_eq("bad_valid", 64'(ov0),   64'd0);
    start = 1'b1; cycle(); start = 1'b0;
    check_eq("restart_err",  64'(err0),  64'd0);
    check_eq("restart_addr", 64'(addr0), 64'd0);

    // Corrupted tag at address 3.
    cor_en = 1'b1; cor_at = 4'd3;
    repeat (10) cycle();
    check_eq("tag_err",   64'(err0),  64'd1);
    check_eq("tag_done",  64'(done0), 64'd1);
    check_eq("tag_valid", 64'(ov0),   64'd0);
    check_eq("tag_outpc", 64'(pc0),   64'd2);
    cor_en = 1'b0;

    // Asynchronous reset in the middle of a run.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (3) cycle();
    #2 rst = 1'b0;
    #1;
    m0 = mdl_rst(); m1 = mdl_rst();
    compare_both();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start          = ($urandom_range(0, 9) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_addr  = 4'($urandom_range(0, 9));
      cor_en         = ($urandom_range(0, 19) == 0);
      cor_at         = 4'($urandom_range(0, PL - 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
